cma_coeff_update: RTL and testbench
===================================

Name: cma_coeff_update

Overview:
- Coefficient-adaptation stage directly downstream of the CMA error block.
- Consumes the per-sample CMA error and the equalizer input stream, and applies the update w[k] <= w[k] - mu*e[n]*x[n-ERR_LAT-k].
- Works serially, one tap per cycle, and drives the flattened coefficient bus back into the FIR.
- The learning rate mu is a power-of-two right shift.

Parameters:
- FIR_LEN, 21, number of taps (odd); centre tap index FIR_LEN/2.
- NB_COEFF, 8, coefficient and error width (signed).
- NBF_COEFF, 7, coefficient and error fractional bits.
- NB_IN, 18, input sample width (signed).
- NBF_IN, 15, input sample fractional bits.
- ERR_LAT, 2, cycles between x[n] at i_sample and its error at i_error.
- UPD_DECIM, 4, valid samples per update trigger (1 = every sample).
- NB_SHIFT, 4, width of i_mu_shift.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  global enable; when low, all state holds
- i_valid  in  1  sample/error pair valid this cycle
- i_update_en  in  1  allow new updates to start
- i_sample  in  NB_IN  equalizer input x[n] (same stream that feeds the FIR)
- i_error  in  NB_COEFF  CMA error e, aligned to x[n-ERR_LAT]
- i_mu_shift  in  NB_SHIFT  mu = 2^-i_mu_shift
- o_coeffs  out  FIR_LEN*NB_COEFF  taps; tap k at bits [k*NB_COEFF +: NB_COEFF]
- o_busy  out  1  update sequence in progress
- o_update_done  out  1  one-cycle pulse when the last tap has been written

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - centre tap = 2^(NB_COEFF-1)-1 (127, ~1.0); all other taps 0.
  - Delay line, decimation counter, tap index and captured error cleared.
  - FSM in IDLE; o_busy=0; o_update_done=0.
- Delay line:
  - FIR_LEN+ERR_LAT samples; shifts on each i_en && i_valid, independent of FSM state.
  - Entry d[0] = newest sample.
- Decimation counter: counts i_en && i_valid modulo UPD_DECIM; trigger when the counter equals 0.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE when trigger && i_update_en && i_en.
    - Capture i_error into e_r.
    - Snapshot d[ERR_LAT .. ERR_LAT+FIR_LEN-1] into x_r[0..FIR_LEN-1], using the line contents before this cycle's shift.
    - Capture i_mu_shift into sh_r.
    - Tap index k = 0.
  - UPDATE: each cycle with i_en high, write tap k and increment k. After k = FIR_LEN-1 is written, go to DONE. If i_en is low, hold.
  - DONE: o_update_done=1 for exactly one cycle, then IDLE.
  - o_busy = (state != IDLE).
- Triggers while busy are dropped; they are not queued. The decimation counter keeps counting.
- Latency:
  - Trigger edge t; tap k written at edge t+1+k.
  - o_update_done high in cycle t+FIR_LEN+1.
  - Earliest next start at edge t+FIR_LEN+2.
- Arithmetic, per tap:
  - P = e_r*x_r[k]: signed, NB_COEFF+NB_IN bits, NBF_COEFF+NBF_IN fractional bits.
  - delta = P >>> (NBF_IN + sh_r): arithmetic shift, truncation toward -inf, result at NBF_COEFF fractional bits.
  - w_new = w - delta, computed at full width, then saturated to [-2^(NB_COEFF-1), 2^(NB_COEFF-1)-1]. No wrap-around is permitted.
- o_coeffs is driven directly from the tap registers; a write is visible in the cycle after its edge.
- i_update_en deasserted mid-sequence: the current sequence completes; no new start.
- Reset mid-sequence: everything returns to reset values. Partially updated taps are restored to their initial values.

Decomposition:
- Shared package cma_pkg:
  - Default FIR_LEN, NB_COEFF/NBF_COEFF, NB_IN/NBF_IN.
  - Centre-tap init constant.
  - FSM state encoding.
  - Saturate function (wide -> NB_COEFF).
- One natural sub-module, cma_tap_mac: combinational multiply/shift/subtract/saturate for one tap, instantiated once and time-shared across taps.

Test Plan:
- Reset:
  - Assert i_reset for 2 cycles.
  - Expect o_coeffs tap10=127, all others 0; o_busy=0; o_update_done=0.
- Zero error:
  - Drive i_error=0, random samples, UPD_DECIM=4.
  - After each o_update_done, o_coeffs is unchanged from reset.
  - o_update_done pulses exactly 22 cycles after each accepted trigger.
- Single-tap arithmetic:
  - Impulse x=16384 (0.5) followed by zeros, i_error=64 (0.5), i_mu_shift=3, with the trigger timed so the impulse lands in x_r[3].
  - Expect tap3 = -4; all other taps unchanged.
- Saturation:
  - Constant x=-131072 (-4.0), i_error=127, i_mu_shift=0.
  - Expect every tap = 127 after one update; no wrap-around to negative values.
  - Flip error to -128 and x to -131072: all taps reach -128.
- Busy/drop and decimation:
  - UPD_DECIM=4, continuous valid.
  - Triggers falling inside a busy window are ignored.
  - Updates start every 24 valid cycles (first trigger count >= 22 past the previous start).
  - o_busy high for 22 cycles each time.
- Reset mid-update:
  - Assert i_reset at UPDATE k=5 with nonzero error.
  - Next cycle: taps back to init, state IDLE, o_busy=0, no o_update_done pulse.

Source files
------------

// File: rtl/cma_pkg.sv
// Shared constants, FSM encoding and saturation helper for the CMA coefficient-update stage.
package cma_pkg;

  localparam int FIR_LEN_D   = 21;
  localparam int NB_COEFF_D  = 8;
  localparam int NBF_COEFF_D = 7;
  localparam int NB_IN_D     = 18;
  localparam int NBF_IN_D    = 15;

  // Centre tap starts at the largest positive coefficient, just under 1.0.
  localparam int CENTRE_INIT = 2 ** (NB_COEFF_D - 1) - 1;

  // Width of w - delta before saturation: product width plus one guard bit.
  localparam int WIDE_W = NB_COEFF_D + NB_IN_D + 1;

  localparam logic signed [WIDE_W-1:0] COEFF_MAX = WIDE_W'(CENTRE_INIT);
  localparam logic signed [WIDE_W-1:0] COEFF_MIN = ~COEFF_MAX;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic signed [NB_COEFF_D-1:0] sat_coeff(input logic signed [WIDE_W-1:0] v);
    if (v > COEFF_MAX) begin
      return COEFF_MAX[NB_COEFF_D-1:0];
    end else if (v < COEFF_MIN) begin
      return COEFF_MIN[NB_COEFF_D-1:0];
    end else begin
      return v[NB_COEFF_D-1:0];
    end
  endfunction

endpackage

// File: rtl/cma_tap_mac.sv
// One-tap update datapath: w_new = sat(w - ((e * x) >>> (NBF_IN + sh))).
module cma_tap_mac
  import cma_pkg::*;
#(
  parameter int NB_COEFF = NB_COEFF_D,
  parameter int NB_IN    = NB_IN_D,
  parameter int NBF_IN   = NBF_IN_D,
  parameter int NB_SHIFT = 4
) (
  input  logic signed [NB_COEFF-1:0] w,
  input  logic signed [NB_COEFF-1:0] e,
  input  logic signed [NB_IN-1:0]    x,
  input  logic        [NB_SHIFT-1:0] sh,
  output logic signed [NB_COEFF-1:0] w_new
);

  localparam int PW = NB_COEFF + NB_IN;
  localparam int SW = $clog2(NBF_IN + 2 ** NB_SHIFT) + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;
  logic signed [PW:0]   diff;
  logic        [SW-1:0] sh_tot;

  assign prod   = PW'(e) * PW'(x);
  assign sh_tot = SW'(NBF_IN) + SW'(sh);
  // Arithmetic shift floors toward -inf and leaves delta at the coefficient's fractional scale.
  assign delta  = prod >>> sh_tot;
  assign diff   = (PW + 1)'(w) - (PW + 1)'(delta);
  assign w_new  = sat_coeff(diff);

endmodule

// File: rtl/cma_coeff_update.sv
// Serial CMA tap adaptation: snapshots error and delayed inputs on a trigger, then updates one tap per cycle.
module cma_coeff_update
  import cma_pkg::*;
#(
  parameter int FIR_LEN   = FIR_LEN_D,
  parameter int NB_COEFF  = NB_COEFF_D,
  parameter int NBF_COEFF = NBF_COEFF_D,
  parameter int NB_IN     = NB_IN_D,
  parameter int NBF_IN    = NBF_IN_D,
  parameter int ERR_LAT   = 2,
  parameter int UPD_DECIM = 4,
  parameter int NB_SHIFT  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_en,
  input  logic                         i_valid,
  input  logic                         i_update_en,
  input  logic signed [NB_IN-1:0]      i_sample,
  input  logic signed [NB_COEFF-1:0]   i_error,
  input  logic        [NB_SHIFT-1:0]   i_mu_shift,
  output logic [FIR_LEN*NB_COEFF-1:0]  o_coeffs,
  output logic                         o_busy,
  output logic                         o_update_done,
  output logic [1:0]                   o_state
);

  localparam int DL = FIR_LEN + ERR_LAT;
  localparam int KW = $clog2(FIR_LEN + 1);
  localparam int CW = (UPD_DECIM > 1) ? $clog2(UPD_DECIM) : 1;
  localparam logic signed [NB_COEFF-1:0] W_INIT = NB_COEFF'(CENTRE_INIT);

  logic signed [NB_IN-1:0]    d   [DL];
  logic signed [NB_IN-1:0]    x_r [FIR_LEN];
  logic signed [NB_COEFF-1:0] w   [FIR_LEN];
  logic signed [NB_COEFF-1:0] e_r;
  logic signed [NB_COEFF-1:0] w_new;
  logic        [NB_SHIFT-1:0] sh_r;
  logic        [KW-1:0]       k;
  logic        [CW-1:0]       dcnt;
  state_t                     state, state_nxt;

  logic shift_en, trig, start, upd, last;

  assign shift_en = i_en && i_valid;
  assign trig     = shift_en && (dcnt == '0);
  assign start    = (state == ST_IDLE) && trig && i_update_en;
  assign upd      = (state == ST_UPDATE) && i_en;
  assign last     = (k == KW'(FIR_LEN - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DL; i++) d[i] <= '0;
      dcnt <= '0;
    end else if (shift_en) begin
      d[0] <= i_sample;
      for (int i = 1; i < DL; i++) d[i] <= d[i-1];
      dcnt <= (dcnt == CW'(UPD_DECIM - 1)) ? '0 : dcnt + 1'b1;
    end
  end

  // Snapshot reads the line as it was before this cycle's shift.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int j = 0; j < FIR_LEN; j++) x_r[j] <= '0;
      e_r  <= '0;
      sh_r <= '0;
      k    <= '0;
    end else if (start) begin
      for (int j = 0; j < FIR_LEN; j++) x_r[j] <= d[ERR_LAT + j];
      e_r  <= i_error;
      sh_r <= i_mu_shift;
      k    <= '0;
    end else if (upd) begin
      k <= k + 1'b1;
    end
  end

  cma_tap_mac #(
    .NB_COEFF (NB_COEFF),
    .NB_IN    (NB_IN),
    .NBF_IN   (NBF_IN),
    .NB_SHIFT (NB_SHIFT)
  ) u_mac (
    .w     (w[k]),
    .e     (e_r),
    .x     (x_r[k]),
    .sh    (sh_r),
    .w_new (w_new)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int j = 0; j < FIR_LEN; j++) w[j] <= (j == FIR_LEN / 2) ? W_INIT : '0;
    end else if (upd) begin
      w[k] <= w_new;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)       state_nxt = ST_UPDATE;
      ST_UPDATE: if (upd && last) state_nxt = ST_DONE;
      ST_DONE:   if (i_en)        state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (state != ST_IDLE);
    o_update_done = (state == ST_DONE);
    o_state       = state;
    o_coeffs      = '0;
    for (int j = 0; j < FIR_LEN; j++) o_coeffs[j*NB_COEFF +: NB_COEFF] = w[j];
  end

endmodule

// File: tb/tb_cma_coeff_update.sv
// Directed bench for cma_coeff_update: reset, zero error, single-tap arithmetic, saturation, drop/decimation, mid-update reset.
module tb_cma_coeff_update;

  localparam int FIR_LEN  = 21;
  localparam int NB_COEFF = 8;
  localparam int NB_IN    = 18;
  localparam int CENTRE   = FIR_LEN / 2;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        en = 1'b1;
  logic                        valid = 1'b0;
  logic                        update_en = 1'b0;
  logic signed [NB_IN-1:0]     sample = '0;
  logic signed [NB_COEFF-1:0]  error = '0;
  logic [3:0]                  mu_shift = '0;
  logic [FIR_LEN*NB_COEFF-1:0] coeffs;
  logic                        busy;
  logic                        update_done;
  logic [1:0]                  state;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  logic [NB_COEFF-1:0] exp_q[$];

  cma_coeff_update #(.UPD_DECIM(4)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_valid       (valid),
    .i_update_en   (update_en),
    .i_sample      (sample),
    .i_error       (error),
    .i_mu_shift    (mu_shift),
    .o_coeffs      (coeffs),
    .o_busy        (busy),
    .o_update_done (update_done),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tap(input int k);
    logic signed [NB_COEFF-1:0] v;
    v = coeffs[k*NB_COEFF +: NB_COEFF];
    return int'(v);
  endfunction

  // One clock of stimulus; outputs are read 1 time unit after the edge.
  task automatic drive(input logic v, input logic u, input logic signed [NB_IN-1:0] s,
                       input logic signed [NB_COEFF-1:0] e);
    valid = v; update_en = u; sample = s; error = e;
    @(posedge clk);
    #1;
    if (v) vcnt++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    vcnt = 0;
  endtask

  task automatic push_init();
    for (int k = 0; k < FIR_LEN; k++) exp_q.push_back((k == CENTRE) ? 8'sd127 : 8'sd0);
  endtask

  task automatic push_all(input logic signed [NB_COEFF-1:0] v);
    for (int k = 0; k < FIR_LEN; k++) exp_q.push_back(v);
  endtask

  task automatic check_taps(input string tag);
    logic signed [NB_COEFF-1:0] e8;
    for (int k = 0; k < FIR_LEN; k++) begin
      e8 = exp_q.pop_front();
      check_eq($sformatf("%s_tap%0d", tag, k), tap(k), int'(e8));
    end
  endtask

  // Drives valid samples with updates blocked until at least pre samples are in and the
  // decimation phase is at zero, then drives the trigger sample with updates allowed.
  task automatic run_trigger(input int pre, input bit rnd, input logic signed [NB_IN-1:0] s,
                             input logic signed [NB_COEFF-1:0] e);
    int n;
    n = 0;
    while (!((vcnt % 4 == 0) && (n >= pre))) begin
      drive(1'b1, 1'b0, rnd ? NB_IN'($urandom) : s, e);
      n++;
    end
    drive(1'b1, 1'b1, rnd ? NB_IN'($urandom) : s, e);
  endtask

  // Latency counts edges from the trigger edge to the edge closing the done cycle.
  task automatic wait_done(input string tag);
    int lat;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      idle();
      if (update_done) lat = n + 1;
    end
    check_eq({tag, "_done_latency"}, lat, FIR_LEN + 1);
    idle();
    check_eq({tag, "_done_width"}, int'(update_done), 0);
    check_eq({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    int starts[$];
    int runs[$];
    int run;
    int pulses;
    logic prev_busy;

    // Reset
    do_reset();
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(update_done), 0);
    check_eq("rst_state", int'(state), 0);
    push_init();
    check_taps("rst");

    // Zero error leaves the taps untouched
    for (int r = 0; r < 2; r++) begin
      mu_shift = 4'($urandom_range(0, 15));
      run_trigger(1, 1'b1, '0, '0);
      check_eq($sformatf("zero%0d_busy_start", r), int'(busy), 1);
      wait_done($sformatf("zero%0d", r));
      push_init();
      check_taps($sformatf("zero%0d", r));
    end

    // Impulse 0.5 lands in x_r[3]; e = 0.5, mu = 1/8 -> tap3 = -4
    do_reset();
    mu_shift = 4'd3;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, (i == 2) ? 18'sd16384 : 18'sd0, '0);
    drive(1'b1, 1'b1, '0, 8'sd64);
    wait_done("imp");
    for (int k = 0; k < FIR_LEN; k++)
      exp_q.push_back((k == 3) ? -8'sd4 : (k == CENTRE) ? 8'sd127 : 8'sd0);
    check_taps("imp");

    // Saturation high then low
    do_reset();
    mu_shift = 4'd0;
    run_trigger(FIR_LEN + 3, 1'b0, -18'sd131072, 8'sd127);
    wait_done("sat_hi");
    push_all(8'sd127);
    check_taps("sat_hi");
    run_trigger(0, 1'b0, -18'sd131072, -8'sd128);
    wait_done("sat_lo");
    push_all(-8'sd128);
    check_taps("sat_lo");

    // Busy windows drop triggers; decimation keeps counting
    do_reset();
    prev_busy = 1'b0;
    run = 0;
    for (int v = 0; v < 76; v++) begin
      drive(1'b1, 1'b1, NB_IN'($urandom), '0);
      if (busy && !prev_busy) starts.push_back(v);
      if (busy) run++;
      if (!busy && prev_busy) begin
        runs.push_back(run);
        run = 0;
      end
      prev_busy = busy;
    end
    check_eq("drop_num_starts", starts.size(), 4);
    check_eq("drop_num_runs", runs.size(), 3);
    check_eq("drop_first_start", (starts.size() > 0) ? starts[0] : -1, 0);
    for (int i = 1; i < 4; i++)
      check_eq($sformatf("drop_gap%0d", i), (starts.size() > i) ? starts[i] - starts[i-1] : -1, 24);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("drop_busy_len%0d", i), (runs.size() > i) ? runs[i] : -1, FIR_LEN + 1);

    // Reset while tap 5 is next to be written
    do_reset();
    mu_shift = 4'd0;
    run_trigger(FIR_LEN + 3, 1'b0, -18'sd131072, 8'sd127);
    for (int i = 0; i < 5; i++) idle();
    check_eq("mid_tap0_written", tap(0), 127);
    check_eq("mid_tap5_pending", tap(5), 0);
    check_eq("mid_busy", int'(busy), 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_state", int'(state), 0);
    check_eq("mid_rst_done", int'(update_done), 0);
    push_init();
    check_taps("mid_rst");
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      idle();
      if (update_done) pulses++;
    end
    check_eq("mid_no_done_pulse", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
